register_file_2r1w: RTL and testbench

// - Next-generation CPU register file: parametrised width/depth, two independent registered read ports,
//   one write port and one increment/decrement port for pointer/index registers (post-inc/pre-dec addressing).
// - Sits between the decode/control unit and the ALU; read ports feed the ALU A/B operands and the address unit.

---
 rtl/register_file_pkg.sv | 13 +
 rtl/register_file_next_value.sv | 32 +++
 rtl/register_file_2r1w.sv | 82 ++++++++
 tb/tb_register_file_2r1w.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/register_file_pkg.sv
// Shared types and helpers for the 2-read/1-write register file with an increment/decrement port.
package register_file_pkg;

    typedef enum logic {
        INCDEC_INC = 1'b0,
        INCDEC_DEC = 1'b1
    } incdec_dir_e;

    function automatic int unsigned num_regs(input int unsigned addr_width);
        return 32'(1) << addr_width;
    endfunction

endpackage

// File: rtl/register_file_next_value.sv
// Next-value logic for one register: write beats incdec, incdec wraps modulo 2**DATA_WIDTH.
module register_file_next_value
    import register_file_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] i_cur_value,
    input  logic                  i_write_hit,
    input  logic [DATA_WIDTH-1:0] i_write_data,
    input  logic                  i_incdec_hit,
    input  incdec_dir_e           i_incdec_dir,
    output logic [DATA_WIDTH-1:0] o_next_value_c,
    output logic                  o_wrap_c
);

    always_comb begin
        o_next_value_c = i_cur_value;
        o_wrap_c       = 1'b0;
        if (i_write_hit) begin
            o_next_value_c = i_write_data;
        end else if (i_incdec_hit) begin
            if (i_incdec_dir == INCDEC_INC) begin
                o_next_value_c = i_cur_value + DATA_WIDTH'(1);
                o_wrap_c       = (i_cur_value == {DATA_WIDTH{1'b1}});
            end else begin
                o_next_value_c = i_cur_value - DATA_WIDTH'(1);
                o_wrap_c       = (i_cur_value == {DATA_WIDTH{1'b0}});
            end
        end
    end

endmodule

// File: rtl/register_file_2r1w.sv
// CPU register file: two registered read ports with write-first bypass, one write port, one incdec port.
module register_file_2r1w
    import register_file_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 2,
    parameter bit          ZERO_REG   = 1'b0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  write_enable,
    input  logic [ADDR_WIDTH-1:0] write_address,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic                  incdec_enable,
    input  logic [ADDR_WIDTH-1:0] incdec_address,
    input  logic                  incdec_dir,
    input  logic [ADDR_WIDTH-1:0] read_address_a,
    output logic [DATA_WIDTH-1:0] read_data_a,
    input  logic [ADDR_WIDTH-1:0] read_address_b,
    output logic [DATA_WIDTH-1:0] read_data_b,
    output logic                  incdec_wrap
);

    localparam int unsigned NUM_REGS = num_regs(ADDR_WIDTH);

    logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];
    logic [DATA_WIDTH-1:0] w_next [NUM_REGS];
    logic [NUM_REGS-1:0]   w_wrap;
    logic [DATA_WIDTH-1:0] r_read_data_a;
    logic [DATA_WIDTH-1:0] r_read_data_b;
    logic                  r_incdec_wrap;

    // Per-register next value; a hardwired zero register never changes and never wraps.
    for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
        if (ZERO_REG && (i == 0)) begin : g_zero
            assign w_next[i] = '0;
            assign w_wrap[i] = 1'b0;
        end else begin : g_live
            logic w_write_hit;
            logic w_incdec_hit;

            assign w_write_hit  = write_enable  && (write_address  == ADDR_WIDTH'(i));
            assign w_incdec_hit = incdec_enable && (incdec_address == ADDR_WIDTH'(i));

            register_file_next_value #(
                .DATA_WIDTH (DATA_WIDTH)
            ) u_next_value (
                .i_cur_value    (r_regs[i]),
                .i_write_hit    (w_write_hit),
                .i_write_data   (write_data),
                .i_incdec_hit   (w_incdec_hit),
                .i_incdec_dir   (incdec_dir_e'(incdec_dir)),
                .o_next_value_c (w_next[i]),
                .o_wrap_c       (w_wrap[i])
            );
        end
    end

    // Reads select from the next-value vector, which gives the write-first bypass for free.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int j = 0; j < NUM_REGS; j++) begin
                r_regs[j] <= '0;
            end
            r_read_data_a <= '0;
            r_read_data_b <= '0;
            r_incdec_wrap <= 1'b0;
        end else begin
            for (int j = 0; j < NUM_REGS; j++) begin
                r_regs[j] <= w_next[j];
            end
            r_read_data_a <= w_next[read_address_a];
            r_read_data_b <= w_next[read_address_b];
            r_incdec_wrap <= |w_wrap;
        end
    end

    assign read_data_a = r_read_data_a;
    assign read_data_b = r_read_data_b;
    assign incdec_wrap = r_incdec_wrap;

endmodule

// File: tb/tb_register_file_2r1w.sv
// Directed bench for register_file_2r1w: one default instance and one ZERO_REG=1 instance on shared inputs.
module tb_register_file_2r1w;

    logic       clk = 1'b0;
    logic       reset;
    logic       write_enable;
    logic [1:0] write_address;
    logic [7:0] write_data;
    logic       incdec_enable;
    logic [1:0] incdec_address;
    logic       incdec_dir;
    logic [1:0] read_address_a;
    logic [1:0] read_address_b;
    logic [7:0] read_data_a,   z_read_data_a;
    logic [7:0] read_data_b,   z_read_data_b;
    logic       incdec_wrap,   z_incdec_wrap;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    register_file_2r1w #(.DATA_WIDTH(8), .ADDR_WIDTH(2), .ZERO_REG(1'b0)) dut (
        .clk(clk), .reset(reset),
        .write_enable(write_enable), .write_address(write_address), .write_data(write_data),
        .incdec_enable(incdec_enable), .incdec_address(incdec_address), .incdec_dir(incdec_dir),
        .read_address_a(read_address_a), .read_data_a(read_data_a),
        .read_address_b(read_address_b), .read_data_b(read_data_b),
        .incdec_wrap(incdec_wrap)
    );

    register_file_2r1w #(.DATA_WIDTH(8), .ADDR_WIDTH(2), .ZERO_REG(1'b1)) dut_z (
        .clk(clk), .reset(reset),
        .write_enable(write_enable), .write_address(write_address), .write_data(write_data),
        .incdec_enable(incdec_enable), .incdec_address(incdec_address), .incdec_dir(incdec_dir),
        .read_address_a(read_address_a), .read_data_a(z_read_data_a),
        .read_address_b(read_address_b), .read_data_b(z_read_data_b),
        .incdec_wrap(z_incdec_wrap)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        write_enable  = 1'b0;
        incdec_enable = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle();
        write_address = 2'd0; write_data = 8'h00;
        incdec_address = 2'd0; incdec_dir = 1'b0;
        read_address_a = 2'd0; read_address_b = 2'd0;
        step();
        step();
        reset = 1'b0;
        for (int a = 0; a < 4; a++) begin
            read_address_a = 2'(a);
            read_address_b = 2'(3 - a);
            step();
            checks++;
            if (read_data_a !== 8'h00) begin
                errors++; $display("FAIL reset_a addr %0d got %h want 00", a, read_data_a);
            end
            checks++;
            if (read_data_b !== 8'h00) begin
                errors++; $display("FAIL reset_b addr %0d got %h want 00", 3 - a, read_data_b);
            end
            checks++;
            if (incdec_wrap !== 1'b0) begin
                errors++; $display("FAIL reset_wrap got %b want 0", incdec_wrap);
            end
        end
    endtask

    task automatic test_write_read();
        logic [7:0] vals [4] = '{8'hA5, 8'h5A, 8'hFF, 8'h0F};
        for (int a = 0; a < 4; a++) begin
            write_enable = 1'b1; write_address = 2'(a); write_data = vals[a];
            step();
        end
        idle();
        read_address_a = 2'd0; read_address_b = 2'd3;
        step();
        checks++;
        if (read_data_a !== 8'hA5) begin errors++; $display("FAIL read_r0 got %h want a5", read_data_a); end
        checks++;
        if (read_data_b !== 8'h0F) begin errors++; $display("FAIL read_r3 got %h want 0f", read_data_b); end
        read_address_a = 2'd1; read_address_b = 2'd2;
        step();
        checks++;
        if (read_data_a !== 8'h5A) begin errors++; $display("FAIL read_r1 got %h want 5a", read_data_a); end
        checks++;
        if (read_data_b !== 8'hFF) begin errors++; $display("FAIL read_r2 got %h want ff", read_data_b); end
    endtask

    task automatic test_bypass();
        write_enable = 1'b1; write_address = 2'd1; write_data = 8'h33;
        read_address_a = 2'd1; read_address_b = 2'd0;
        step();
        checks++;
        if (read_data_a !== 8'h33) begin errors++; $display("FAIL bypass_a got %h want 33", read_data_a); end
        idle();
        read_address_b = 2'd1;
        step();
        checks++;
        if (read_data_b !== 8'h33) begin errors++; $display("FAIL after_bypass_b got %h want 33", read_data_b); end
        checks++;
        if (read_data_a !== read_data_b) begin
            errors++; $display("FAIL same_addr got a=%h b=%h want equal", read_data_a, read_data_b);
        end
    endtask

    task automatic test_incdec_wrap();
        read_address_b = 2'd2;
        incdec_enable = 1'b1; incdec_address = 2'd2; incdec_dir = 1'b0;
        step();
        checks++;
        if (read_data_b !== 8'h00) begin errors++; $display("FAIL inc_ff got %h want 00", read_data_b); end
        checks++;
        if (incdec_wrap !== 1'b1) begin errors++; $display("FAIL inc_wrap got %b want 1", incdec_wrap); end
        idle();
        step();
        checks++;
        if (incdec_wrap !== 1'b0) begin errors++; $display("FAIL wrap_pulse got %b want 0", incdec_wrap); end
        incdec_enable = 1'b1; incdec_dir = 1'b1;
        step();
        checks++;
        if (read_data_b !== 8'hFF) begin errors++; $display("FAIL dec_00 got %h want ff", read_data_b); end
        checks++;
        if (incdec_wrap !== 1'b1) begin errors++; $display("FAIL dec_wrap got %b want 1", incdec_wrap); end
        step();
        checks++;
        if (read_data_b !== 8'hFE) begin errors++; $display("FAIL dec_ff got %h want fe", read_data_b); end
        checks++;
        if (incdec_wrap !== 1'b0) begin errors++; $display("FAIL dec_nowrap got %b want 0", incdec_wrap); end
        idle();
    endtask

    task automatic test_write_incdec();
        // Same address: write wins and a would-be wrap is suppressed.
        write_enable = 1'b1; write_address = 2'd3; write_data = 8'h10;
        incdec_enable = 1'b1; incdec_address = 2'd3; incdec_dir = 1'b0;
        read_address_b = 2'd3;
        step();
        checks++;
        if (read_data_b !== 8'h10) begin errors++; $display("FAIL collide_r3 got %h want 10", read_data_b); end
        checks++;
        if (incdec_wrap !== 1'b0) begin errors++; $display("FAIL collide_wrap got %b want 0", incdec_wrap); end
        write_address = 2'd2; write_data = 8'hFF; incdec_enable = 1'b0;
        step();
        write_data = 8'h55; incdec_enable = 1'b1; incdec_address = 2'd2;
        read_address_b = 2'd2;
        step();
        checks++;
        if (read_data_b !== 8'h55) begin errors++; $display("FAIL collide_r2 got %h want 55", read_data_b); end
        checks++;
        if (incdec_wrap !== 1'b0) begin errors++; $display("FAIL collide_wrap_ff got %b want 0", incdec_wrap); end
        // Different addresses: both applied.
        write_address = 2'd0; write_data = 8'h20;
        incdec_address = 2'd1; incdec_dir = 1'b0;
        read_address_a = 2'd0; read_address_b = 2'd1;
        step();
        checks++;
        if (read_data_a !== 8'h20) begin errors++; $display("FAIL split_r0 got %h want 20", read_data_a); end
        checks++;
        if (read_data_b !== 8'h34) begin errors++; $display("FAIL split_r1 got %h want 34", read_data_b); end
        idle();
        read_address_a = 2'd3;
        step();
        checks++;
        if (read_data_a !== 8'h10) begin errors++; $display("FAIL hold_r3 got %h want 10", read_data_a); end
        checks++;
        if (read_data_b !== 8'h34) begin errors++; $display("FAIL hold_r1 got %h want 34", read_data_b); end
    endtask

    task automatic test_reset_mid();
        reset = 1'b1;
        write_enable = 1'b1; write_address = 2'd1; write_data = 8'h77;
        incdec_enable = 1'b1; incdec_address = 2'd0; incdec_dir = 1'b1;
        read_address_a = 2'd1; read_address_b = 2'd0;
        step();
        checks++;
        if (read_data_a !== 8'h00) begin errors++; $display("FAIL rst_mid_a got %h want 00", read_data_a); end
        checks++;
        if (read_data_b !== 8'h00) begin errors++; $display("FAIL rst_mid_b got %h want 00", read_data_b); end
        checks++;
        if (incdec_wrap !== 1'b0) begin errors++; $display("FAIL rst_mid_wrap got %b want 0", incdec_wrap); end
        reset = 1'b0;
        idle();
        read_address_b = 2'd3;
        step();
        checks++;
        if (read_data_a !== 8'h00) begin errors++; $display("FAIL rst_r1 got %h want 00", read_data_a); end
        checks++;
        if (read_data_b !== 8'h00) begin errors++; $display("FAIL rst_r3 got %h want 00", read_data_b); end
    endtask

    task automatic test_zero_reg();
        write_enable = 1'b1; write_address = 2'd0; write_data = 8'hAA;
        read_address_a = 2'd0; read_address_b = 2'd0;
        step();
        checks++;
        if (z_read_data_a !== 8'h00) begin errors++; $display("FAIL zero_bypass got %h want 00", z_read_data_a); end
        checks++;
        if (read_data_a !== 8'hAA) begin errors++; $display("FAIL plain_r0 got %h want aa", read_data_a); end
        idle();
        incdec_enable = 1'b1; incdec_address = 2'd0; incdec_dir = 1'b1;
        step();
        checks++;
        if (z_read_data_b !== 8'h00) begin errors++; $display("FAIL zero_dec got %h want 00", z_read_data_b); end
        checks++;
        if (z_incdec_wrap !== 1'b0) begin errors++; $display("FAIL zero_wrap got %b want 0", z_incdec_wrap); end
        checks++;
        if (read_data_b !== 8'hA9) begin errors++; $display("FAIL plain_dec got %h want a9", read_data_b); end
        idle();
        write_enable = 1'b1; write_address = 2'd2; write_data = 8'h3C;
        read_address_a = 2'd2;
        step();
        checks++;
        if (z_read_data_a !== 8'h3C) begin errors++; $display("FAIL zero_build_r2 got %h want 3c", z_read_data_a); end
        idle();
        step();
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_bypass();
        test_incdec_wrap();
        test_write_incdec();
        test_reset_mid();
        test_zero_reg();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
